vga_timing_gen: RTL and testbench

- Upstream timing source for every pixel-stage renderer in the Pac-Man display path: walls, pellets, sprites and the pixel mixer.
- Divides the 100 MHz system clock into a 25 MHz pixel-enable strobe.
- Runs the 800x525 horizontal/vertical scan counters.
- Produces the hCount/vCount/bright bus that renderers decode, plus hSync/vSync for the VGA connector and frame/line strobes for game-logic update timing.

---
 rtl/vga_pkg.sv | 19 +
 rtl/pixel_clk_div.sv | 28 ++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, bus widths and palette constants for the display path.
package vga_pkg;
    localparam int CNT_W   = 10;
    localparam int COLOR_W = 12;

    localparam int CLK_DIV_DEF        = 4;
    localparam int H_TOTAL_DEF        = 800;
    localparam int H_SYNC_END_DEF     = 96;
    localparam int H_BRIGHT_START_DEF = 144;
    localparam int H_BRIGHT_END_DEF   = 784;
    localparam int V_TOTAL_DEF        = 525;
    localparam int V_SYNC_END_DEF     = 2;
    localparam int V_BRIGHT_START_DEF = 35;
    localparam int V_BRIGHT_END_DEF   = 515;

    localparam logic [COLOR_W-1:0] WALL  = 12'h00F;
    localparam logic [COLOR_W-1:0] BLACK = 12'h000;
    localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;
endpackage

// File: rtl/pixel_clk_div.sv
// Strobe generator: tick is high for one clk out of every DIV; tick_next is its next-state value.
module pixel_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic tick_next
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt, cnt_nxt;

    assign cnt_nxt   = (cnt == LAST) ? '0 : cnt + 1'b1;
    assign tick_next = (cnt_nxt == LAST);

    // tick is a register that mirrors (cnt == LAST) without an output decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= tick_next;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// 800x525 VGA scan counters with registered sync/bright/strobe decodes.
// Optional checkerboard test pattern on rgbTest when DISPLAY_TESTPAT_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV        = CLK_DIV_DEF,
    parameter int H_TOTAL        = H_TOTAL_DEF,
    parameter int H_SYNC_END     = H_SYNC_END_DEF,
    parameter int H_BRIGHT_START = H_BRIGHT_START_DEF,
    parameter int H_BRIGHT_END   = H_BRIGHT_END_DEF,
    parameter int V_TOTAL        = V_TOTAL_DEF,
    parameter int V_SYNC_END     = V_SYNC_END_DEF,
    parameter int V_BRIGHT_START = V_BRIGHT_START_DEF,
    parameter int V_BRIGHT_END   = V_BRIGHT_END_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pixelEn,
    output logic [CNT_W-1:0]   hCount,
    output logic [CNT_W-1:0]   vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic               lineStart,
    output logic               frameStart,
    output logic [COLOR_W-1:0] rgbTest
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HSE    = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] VSE    = CNT_W'(V_SYNC_END);
    localparam logic [CNT_W-1:0] HBS    = CNT_W'(H_BRIGHT_START);
    localparam logic [CNT_W-1:0] HBE    = CNT_W'(H_BRIGHT_END);
    localparam logic [CNT_W-1:0] VBS    = CNT_W'(V_BRIGHT_START);
    localparam logic [CNT_W-1:0] VBE    = CNT_W'(V_BRIGHT_END);

    logic             pe_nxt;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             bright_nxt;

    pixel_clk_div #(.DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .rst      (reset),
        .tick     (pixelEn),
        .tick_next(pe_nxt)
    );

    always_comb begin
        h_nxt = hCount;
        v_nxt = vCount;
        if (pixelEn) begin
            if (hCount == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vCount == V_LAST) ? '0 : vCount + 1'b1;
            end else begin
                h_nxt = hCount + 1'b1;
            end
        end
    end

    assign bright_nxt = (h_nxt >= HBS) && (h_nxt < HBE) && (v_nxt >= VBS) && (v_nxt < VBE);

    // decodes use next-state counts so they line up with hCount/vCount every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hCount     <= '0;
            vCount     <= '0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            hCount     <= h_nxt;
            vCount     <= v_nxt;
            hSync      <= !(h_nxt < HSE);
            vSync      <= !(v_nxt < VSE);
            bright     <= bright_nxt;
            lineStart  <= pe_nxt && (h_nxt == '0);
            frameStart <= pe_nxt && (h_nxt == '0) && (v_nxt == '0);
        end
    end

`ifdef DISPLAY_TESTPAT_EN
    logic [CNT_W-1:0] hx, vy;
    assign hx = h_nxt - HBS;
    assign vy = v_nxt - VBS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rgbTest <= '0;
        else if (!bright_nxt)
            rgbTest <= BLACK;
        else
            rgbTest <= (hx[3] ^ vy[3]) ? WHITE : WALL;
    end
`else
    assign rgbTest = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced 40x20 raster against a cycle-count arithmetic model.
module tb_vga_timing_gen;
    localparam int D   = 4;
    localparam int HT  = 40, HSE = 6,  HBS = 10, HBE = 34;
    localparam int VT  = 20, VSE = 2,  VBS = 4,  VBE = 16;
    localparam int FRAME_CLKS = HT * VT * D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixelEn, hSync, vSync, bright, lineStart, frameStart;
    logic [9:0]  hCount, vCount;
    logic [11:0] rgbTest;

    vga_timing_gen #(
        .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC_END(HSE), .H_BRIGHT_START(HBS), .H_BRIGHT_END(HBE),
        .V_TOTAL(VT), .V_SYNC_END(VSE), .V_BRIGHT_START(VBS), .V_BRIGHT_END(VBE)
    ) dut (
        .clk(clk), .reset(reset), .pixelEn(pixelEn), .hCount(hCount), .vCount(vCount),
        .hSync(hSync), .vSync(vSync), .bright(bright), .lineStart(lineStart),
        .frameStart(frameStart), .rgbTest(rgbTest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pe;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs, vs, br, ls, fs;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int   h, v;
        logic hs, vs, br;
    } vec_t;

    int vecs = 0, errs = 0;
    int k = 0;
    int last_fs = 0;

    // k = 1 is the cycle right after reset release; n = completed pixel edges
    function automatic obs_t model(input int kk);
        obs_t o;
        int n, h, v;
        n = (kk - 1) / D;
        h = n % HT;
        v = (n / HT) % VT;
        o.pe  = (kk % D) == 0;
        o.h   = 10'(h);
        o.v   = 10'(v);
        o.hs  = h >= HSE;
        o.vs  = v >= VSE;
        o.br  = (h >= HBS) && (h < HBE) && (v >= VBS) && (v < VBE);
        o.ls  = o.pe && (h == 0);
        o.fs  = o.ls && (v == 0);
        o.rgb = 12'h000;
`ifdef DISPLAY_TESTPAT_EN
        if (o.br) o.rgb = ((((h - HBS) / 8) % 2) != (((v - VBS) / 8) % 2)) ? 12'hFFF : 12'h00F;
`endif
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.pe = pixelEn; o.h = hCount; o.v = vCount; o.hs = hSync; o.vs = vSync;
        o.br = bright; o.ls = lineStart; o.fs = frameStart; o.rgb = rgbTest;
        return o;
    endfunction

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = actual();
        vecs++;
        if (a != e) begin
            errs++;
            $display("FAIL %s k=%0d got pe=%b h=%0d v=%0d hs=%b vs=%b br=%b ls=%b fs=%b rgb=%h exp pe=%b h=%0d v=%0d hs=%b vs=%b br=%b ls=%b fs=%b rgb=%h",
                     name, k, a.pe, a.h, a.v, a.hs, a.vs, a.br, a.ls, a.fs, a.rgb,
                     e.pe, e.h, e.v, e.hs, e.vs, e.br, e.ls, e.fs, e.rgb);
        end
    endtask

    task automatic step(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            k++;
            check("scan", model(k));
            if (frameStart) begin
                if (last_fs > 0) begin
                    vecs++;
                    if (k - last_fs != FRAME_CLKS) begin
                        errs++;
                        $display("FAIL frame_period got %0d exp %0d", k - last_fs, FRAME_CLKS);
                    end
                end
                last_fs = k;
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        k = 1;
        last_fs = 0;
        #1;
        check("release", model(1));
    endtask

    // assert reset mid-cycle, away from any edge, and expect an immediate clear
    task automatic async_reset(input int hold);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", '0);
        repeat (hold) @(negedge clk);
        check("rst_hold", '0);
        release_reset();
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{0,  0,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{5,  0,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{6,  0,  1'b1, 1'b0, 1'b0};
        tbl[3]  = '{10, 1,  1'b1, 1'b0, 1'b0};
        tbl[4]  = '{0,  2,  1'b0, 1'b1, 1'b0};
        tbl[5]  = '{9,  4,  1'b1, 1'b1, 1'b0};
        tbl[6]  = '{10, 4,  1'b1, 1'b1, 1'b1};
        tbl[7]  = '{33, 4,  1'b1, 1'b1, 1'b1};
        tbl[8]  = '{34, 4,  1'b1, 1'b1, 1'b0};
        tbl[9]  = '{20, 15, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{39, 15, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{20, 16, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{39, 19, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_state", '0);
        release_reset();

        // boundary table, visited in scan order from one release
        for (int i = 0; i < 13; i++) begin
            int target;
            target = (tbl[i].v * HT + tbl[i].h) * D + 1;
            if (target > k) step(target - k);
            vecs++;
            if (hCount != 10'(tbl[i].h) || vCount != 10'(tbl[i].v) ||
                hSync != tbl[i].hs || vSync != tbl[i].vs || bright != tbl[i].br) begin
                errs++;
                $display("FAIL tbl%0d got h=%0d v=%0d hs=%b vs=%b br=%b exp h=%0d v=%0d hs=%b vs=%b br=%b",
                         i, hCount, vCount, hSync, vSync, bright,
                         tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].br);
            end
        end

        // frame wrap (39,19) -> (0,0) with one frameStart
        step(200);

        // mid-frame reset at (20,10), then a full frame plus margin
        async_reset(2);
        step((10 * HT + 20) * D);
        async_reset(3);
        step(FRAME_CLKS + 300);

        for (int r = 0; r < 6; r++) begin
            step(int'($urandom_range(50, 1500)));
            async_reset(int'($urandom_range(1, 5)));
        end
        step(FRAME_CLKS + 50);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
